// File: rtl/pipe_control.sv
// pipe_control: control half of a five-stage pipeline. Decodes in D, carries
// the control bundle through D->E, E->M and M->W, resolves branches in E,
// detects load-use hazards and produces the forwarding selects.
module pipe_control #(
  parameter bit FULL_BRANCH    = 1'b1,
  parameter bit U_TYPE_EN      = 1'b1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instr_d,
  input  logic                      zero_e,
  input  logic                      lt_e,
  input  logic                      ltu_e,
  output logic [2:0]                imm_src_d,
  output logic [3:0]                alu_control_e,
  output logic                      alu_src_e,
  output logic                      alu_a_pc_e,
  output logic [1:0]                pc_src_e,
  output logic                      mem_write_m,
  output logic [2:0]                addr_ctl_m,
  output logic                      reg_write_w,
  output logic [1:0]                result_src_w,
  output logic [REG_ADDR_WIDTH-1:0] rd_w,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      illegal_w
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                      reg_write;
    logic [1:0]                result_src;
    logic                      mem_write;
    logic                      is_load;
    logic                      branch;
    logic                      jal;
    logic                      jalr;
    logic [3:0]                alu_control;
    logic                      alu_src;
    logic                      alu_a_pc;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      illegal;
  } ctl_t;

  // Shared ALU-op mapping for R and I-ALU; alt selects sub/sra.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0111;
      3'b010:  alu_op = 4'b0101;
      3'b011:  alu_op = 4'b0110;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = alt ? 4'b1011 : 4'b1000;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  endfunction

  // MEM result has priority over WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                         input logic rw_m, input logic [REG_ADDR_WIDTH-1:0] rdm,
                                         input logic rw_w, input logic [REG_ADDR_WIDTH-1:0] rdw);
    if (rw_m && rdm != '0 && rdm == rs)      fwd_sel = 2'b10;
    else if (rw_w && rdw != '0 && rdw == rs) fwd_sel = 2'b01;
    else                                     fwd_sel = 2'b00;
  endfunction

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REG_ADDR_WIDTH-1:0] rs1_f, rs2_f;
  logic [2:0]                imm_src;
  logic                      legal, uses_rs1, uses_rs2;
  logic                      load_use, taken;
  ctl_t                      ctl_d, ctl_e;
  logic                      reg_write_m, illegal_m;
  logic [1:0]                result_src_m;
  logic [REG_ADDR_WIDTH-1:0] rd_m;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign rs1_f  = REG_ADDR_WIDTH'(instr_d[19:15]);
  assign rs2_f  = REG_ADDR_WIDTH'(instr_d[24:20]);

  // D-stage decode; anything not recognised becomes a bubble tagged illegal.
  always_comb begin
    ctl_d    = '0;
    imm_src  = 3'b000;
    legal    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    ctl_d.rd     = REG_ADDR_WIDTH'(instr_d[11:7]);
    ctl_d.funct3 = funct3;
    case (opcode)
      OP_R: begin
        uses_rs2 = 1'b1;
        ctl_d.reg_write   = 1'b1;
        ctl_d.alu_control = alu_op(funct3, funct7[5]);
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_I: begin
        ctl_d.reg_write   = 1'b1;
        ctl_d.alu_src     = 1'b1;
        ctl_d.alu_control = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      OP_LOAD: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.result_src = 2'b01;
        ctl_d.is_load    = 1'b1;
        ctl_d.alu_src    = 1'b1;
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        uses_rs2 = 1'b1;
        imm_src  = 3'b001;
        ctl_d.mem_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
        legal = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        imm_src  = 3'b010;
        ctl_d.branch      = 1'b1;
        ctl_d.alu_control = 4'b0001;
        legal = (funct3 inside {3'b000, 3'b001}) || (FULL_BRANCH && funct3[2]);
      end
      OP_JAL: begin
        uses_rs1 = 1'b0;
        imm_src  = 3'b011;
        ctl_d.reg_write  = 1'b1;
        ctl_d.result_src = 2'b10;
        ctl_d.jal        = 1'b1;
      end
      OP_JALR: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.result_src = 2'b10;
        ctl_d.jalr       = 1'b1;
        ctl_d.alu_src    = 1'b1;
        legal = (funct3 == 3'b000);
      end
      OP_LUI: begin
        uses_rs1 = 1'b0;
        imm_src  = 3'b100;
        ctl_d.reg_write  = 1'b1;
        ctl_d.result_src = 2'b11;
        legal = U_TYPE_EN;
      end
      OP_AUIPC: begin
        uses_rs1 = 1'b0;
        imm_src  = 3'b100;
        ctl_d.reg_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
        ctl_d.alu_a_pc  = 1'b1;
        legal = U_TYPE_EN;
      end
      default: legal = 1'b0;
    endcase
    ctl_d.rs1 = uses_rs1 ? rs1_f : '0;
    ctl_d.rs2 = uses_rs2 ? rs2_f : '0;
    if (!legal) begin
      ctl_d         = '0;
      ctl_d.illegal = 1'b1;
      imm_src       = 3'b000;
    end
  end

  // Immediate select is forced low while reset is held so every output reads 0.
  assign imm_src_d = rst ? 3'b000 : imm_src;

  // E-stage branch/jump resolution and hazard response; flush beats stall.
  always_comb begin
    case (ctl_e.funct3)
      3'b000:  taken = zero_e;
      3'b001:  taken = !zero_e;
      3'b100:  taken = lt_e;
      3'b101:  taken = !lt_e;
      3'b110:  taken = ltu_e;
      3'b111:  taken = !ltu_e;
      default: taken = 1'b0;
    endcase
    if (ctl_e.jalr)                          pc_src_e = 2'b10;
    else if (ctl_e.jal || (ctl_e.branch && taken)) pc_src_e = 2'b01;
    else                                     pc_src_e = 2'b00;
    load_use = ctl_e.is_load && (ctl_e.rd != '0) &&
               ((ctl_e.rd == rs1_f) || (uses_rs2 && ctl_e.rd == rs2_f));
    flush_d  = (pc_src_e != 2'b00);
    flush_e  = flush_d || load_use;
    stall_f  = load_use && !flush_d;
    stall_d  = load_use && !flush_d;
  end

  assign forward_a_e   = fwd_sel(ctl_e.rs1, reg_write_m, rd_m, reg_write_w, rd_w);
  assign forward_b_e   = fwd_sel(ctl_e.rs2, reg_write_m, rd_m, reg_write_w, rd_w);
  assign alu_control_e = ctl_e.alu_control;
  assign alu_src_e     = ctl_e.alu_src;
  assign alu_a_pc_e    = ctl_e.alu_a_pc;

  // D->E register: a flush (branch or load-use) inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ctl_e <= '0;
    else if (flush_e) ctl_e <= '0;
    else              ctl_e <= ctl_d;
  end

  // E->M register advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      addr_ctl_m   <= 3'b000;
      rd_m         <= '0;
      illegal_m    <= 1'b0;
    end else begin
      reg_write_m  <= ctl_e.reg_write;
      result_src_m <= ctl_e.result_src;
      mem_write_m  <= ctl_e.mem_write;
      addr_ctl_m   <= (ctl_e.is_load || ctl_e.mem_write) ? ctl_e.funct3 : 3'b000;
      rd_m         <= ctl_e.rd;
      illegal_m    <= ctl_e.illegal;
    end
  end

  // M->W register advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
      illegal_w    <= 1'b0;
    end else begin
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      illegal_w    <= illegal_m;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares whatever is due that cycle.
module tb_pipe_control;

   logic        clk, rst;
   logic [31:0] instr_d;
   logic        zero_e, lt_e, ltu_e;

   logic [2:0] imm_src_d, addr_ctl_m;
   logic [3:0] alu_control_e;
   logic       alu_src_e, alu_a_pc_e, mem_write_m, reg_write_w;
   logic [1:0] pc_src_e, result_src_w, forward_a_e, forward_b_e;
   logic [4:0] rd_w;
   logic       stall_f, stall_d, flush_d, flush_e, illegal_w;

   logic [2:0] d2_imm_src_d, d2_addr_ctl_m;
   logic [3:0] d2_alu_control_e;
   logic       d2_alu_src_e, d2_alu_a_pc_e, d2_mem_write_m, d2_reg_write_w;
   logic [1:0] d2_pc_src_e, d2_result_src_w, d2_forward_a_e, d2_forward_b_e;
   logic [4:0] d2_rd_w;
   logic       d2_stall_f, d2_stall_d, d2_flush_d, d2_flush_e, d2_illegal_w;

   pipe_control dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .imm_src_d(imm_src_d), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
      .alu_a_pc_e(alu_a_pc_e), .pc_src_e(pc_src_e), .mem_write_m(mem_write_m),
      .addr_ctl_m(addr_ctl_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
      .rd_w(rd_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .illegal_w(illegal_w)
   );

   // Reduced-decode instance: no blt/bge/bltu/bgeu, no lui/auipc.
   pipe_control #(.FULL_BRANCH(1'b0), .U_TYPE_EN(1'b0), .REG_ADDR_WIDTH(5)) dut2 (
      .clk(clk), .rst(rst), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .imm_src_d(d2_imm_src_d), .alu_control_e(d2_alu_control_e), .alu_src_e(d2_alu_src_e),
      .alu_a_pc_e(d2_alu_a_pc_e), .pc_src_e(d2_pc_src_e), .mem_write_m(d2_mem_write_m),
      .addr_ctl_m(d2_addr_ctl_m), .reg_write_w(d2_reg_write_w), .result_src_w(d2_result_src_w),
      .rd_w(d2_rd_w), .forward_a_e(d2_forward_a_e), .forward_b_e(d2_forward_b_e),
      .stall_f(d2_stall_f), .stall_d(d2_stall_d), .flush_d(d2_flush_d), .flush_e(d2_flush_e),
      .illegal_w(d2_illegal_w)
   );

   localparam int S_IMM = 0, S_ALUC = 1, S_ALUSRC = 2, S_APC = 3, S_PCSRC = 4, S_MEMW = 5,
                  S_ADDR = 6, S_RW = 7, S_RES = 8, S_RD = 9, S_FA = 10, S_FB = 11,
                  S_STALLF = 12, S_STALLD = 13, S_FLUSHD = 14, S_FLUSHE = 15, S_ILL = 16,
                  S_ALL = 17, S_D2ILL = 18, S_D2FLUSHD = 19, S_D2FLUSHE = 20;

   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] ADD3  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
   localparam logic [31:0] SUB4  = {7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4, 7'b0110011};
   localparam logic [31:0] ADD7  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};
   localparam logic [31:0] SUB8  = {7'b0100000, 5'd7, 5'd7, 3'b000, 5'd8, 7'b0110011};
   localparam logic [31:0] LW5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
   localparam logic [31:0] ADD6  = {7'b0000000, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
   localparam logic [31:0] SW    = {7'b0000000, 5'd5, 5'd6, 3'b010, 5'd4, 7'b0100011};
   localparam logic [31:0] BNE   = {7'b0000000, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011};
   localparam logic [31:0] BLTU  = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
   localparam logic [31:0] BGE   = {7'b0000000, 5'd2, 5'd1, 3'b101, 5'd0, 7'b1100011};
   localparam logic [31:0] BLT   = {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
   localparam logic [31:0] JALR  = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
   localparam logic [31:0] JAL0  = {20'd0, 5'd0, 7'b1101111};
   localparam logic [31:0] ILL   = 32'h0000007F;
   localparam logic [31:0] MUL   = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
   localparam logic [31:0] LUI9  = {20'h12345, 5'd9, 7'b0110111};
   localparam logic [31:0] AUIPC = {20'h00001, 5'd10, 7'b0010111};
   localparam logic [31:0] SRAI  = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd11, 7'b0010011};

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         S_IMM:      sample = 32'(imm_src_d);
         S_ALUC:     sample = 32'(alu_control_e);
         S_ALUSRC:   sample = 32'(alu_src_e);
         S_APC:      sample = 32'(alu_a_pc_e);
         S_PCSRC:    sample = 32'(pc_src_e);
         S_MEMW:     sample = 32'(mem_write_m);
         S_ADDR:     sample = 32'(addr_ctl_m);
         S_RW:       sample = 32'(reg_write_w);
         S_RES:      sample = 32'(result_src_w);
         S_RD:       sample = 32'(rd_w);
         S_FA:       sample = 32'(forward_a_e);
         S_FB:       sample = 32'(forward_b_e);
         S_STALLF:   sample = 32'(stall_f);
         S_STALLD:   sample = 32'(stall_d);
         S_FLUSHD:   sample = 32'(flush_d);
         S_FLUSHE:   sample = 32'(flush_e);
         S_ILL:      sample = 32'(illegal_w);
         S_ALL:      sample = {imm_src_d, alu_control_e, alu_src_e, alu_a_pc_e, pc_src_e,
                               mem_write_m, addr_ctl_m, reg_write_w, result_src_w, rd_w,
                               forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
                               illegal_w};
         S_D2ILL:    sample = 32'(d2_illegal_w);
         S_D2FLUSHD: sample = 32'(d2_flush_d);
         S_D2FLUSHE: sample = 32'(d2_flush_e);
         default:    sample = 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         S_IMM: sel_name = "imm_src_d";       S_ALUC: sel_name = "alu_control_e";
         S_ALUSRC: sel_name = "alu_src_e";    S_APC: sel_name = "alu_a_pc_e";
         S_PCSRC: sel_name = "pc_src_e";      S_MEMW: sel_name = "mem_write_m";
         S_ADDR: sel_name = "addr_ctl_m";     S_RW: sel_name = "reg_write_w";
         S_RES: sel_name = "result_src_w";    S_RD: sel_name = "rd_w";
         S_FA: sel_name = "forward_a_e";      S_FB: sel_name = "forward_b_e";
         S_STALLF: sel_name = "stall_f";      S_STALLD: sel_name = "stall_d";
         S_FLUSHD: sel_name = "flush_d";      S_FLUSHE: sel_name = "flush_e";
         S_ILL: sel_name = "illegal_w";       S_ALL: sel_name = "all_outputs";
         S_D2ILL: sel_name = "dut2_illegal_w"; S_D2FLUSHD: sel_name = "dut2_flush_d";
         S_D2FLUSHE: sel_name = "dut2_flush_e";
         default: sel_name = "unknown";
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      logic [31:0] got;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            got = sample(sb[i].sel);
            n_checks++;
            if (got === sb[i].val) n_pass++;
            else $display("FAIL %s cycle %0d: got %0h expected %0h",
                          sel_name(sb[i].sel), cyc, got, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic tick(input logic [31:0] ins, input logic z, input logic l, input logic lu);
      @(posedge clk);
      #1;
      instr_d = ins;
      zero_e  = z;
      lt_e    = l;
      ltu_e   = lu;
   endtask

   task automatic push_exp(input int off, input int sel, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + off;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; instr_d = NOP; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;

      tick(NOP, 1'b0, 1'b0, 1'b0); push_exp(0, S_ALL, 0);
      tick(NOP, 1'b0, 1'b0, 1'b0); rst = 1'b0; push_exp(0, S_ALL, 0);

      // ALU forwarding from MEM, then from WB
      tick(ADD3, 1'b0, 1'b0, 1'b0);
      push_exp(1, S_ALUC, 0); push_exp(1, S_ALUSRC, 0);
      push_exp(3, S_RW, 1); push_exp(3, S_RD, 3); push_exp(3, S_RES, 0);
      tick(SUB4, 1'b0, 1'b0, 1'b0);
      push_exp(1, S_ALUC, 1); push_exp(1, S_FA, 2); push_exp(1, S_FB, 2);
      tick(ADD7, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      tick(SUB8, 1'b0, 1'b0, 1'b0);
      push_exp(1, S_FA, 1); push_exp(1, S_FB, 1);

      // Load-use stall, then WB forward; store after
      tick(LW5, 1'b0, 1'b0, 1'b0); push_exp(0, S_IMM, 0);
      tick(ADD6, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_STALLF, 1); push_exp(0, S_STALLD, 1);
      push_exp(0, S_FLUSHE, 1); push_exp(0, S_FLUSHD, 0);
      #1;
      n_checks++;
      if (stall_d === 1'b1) n_pass++;
      else $display("FAIL direct stall_d on load-use: got %0b", stall_d);
      tick(ADD6, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_STALLF, 0); push_exp(0, S_FLUSHE, 0);
      push_exp(0, S_ADDR, 2); push_exp(0, S_MEMW, 0);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_FA, 1); push_exp(0, S_FB, 0);
      push_exp(0, S_RW, 1); push_exp(0, S_RES, 1); push_exp(0, S_RD, 5);
      tick(SW, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_IMM, 1); push_exp(1, S_ALUSRC, 1); push_exp(1, S_FA, 1); push_exp(1, S_FB, 0);
      push_exp(2, S_MEMW, 1); push_exp(2, S_ADDR, 2); push_exp(3, S_RW, 0);

      // Branches
      tick(BNE, 1'b0, 1'b0, 1'b0); push_exp(0, S_IMM, 2);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_PCSRC, 1); push_exp(0, S_FLUSHD, 1); push_exp(0, S_FLUSHE, 1);
      push_exp(0, S_ALUC, 1); push_exp(0, S_STALLF, 0);
      #1;
      n_checks++;
      if (flush_d === 1'b1) n_pass++;
      else $display("FAIL direct flush_d on taken bne: got %0b", flush_d);
      tick(NOP, 1'b0, 1'b0, 1'b0); push_exp(0, S_PCSRC, 0); push_exp(0, S_FLUSHE, 0);
      tick(BNE, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b1, 1'b0, 1'b0);
      push_exp(0, S_PCSRC, 0); push_exp(0, S_FLUSHD, 0); push_exp(0, S_FLUSHE, 0);
      tick(BLTU, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b0, 1'b0, 1'b1);
      push_exp(0, S_PCSRC, 1); push_exp(0, S_FLUSHE, 1);
      push_exp(0, S_D2FLUSHE, 0); push_exp(2, S_D2ILL, 1);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      tick(BGE, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b0, 1'b1, 1'b0); push_exp(0, S_PCSRC, 0); push_exp(0, S_FLUSHE, 0);
      tick(BLT, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b0, 1'b1, 1'b0);
      push_exp(0, S_PCSRC, 1); push_exp(0, S_FLUSHD, 1);
      push_exp(0, S_D2FLUSHD, 0); push_exp(0, S_D2FLUSHE, 0);
      push_exp(2, S_D2ILL, 1); push_exp(2, S_ILL, 0);

      // Jumps
      tick(JALR, 1'b0, 1'b0, 1'b0);
      push_exp(1, S_PCSRC, 2); push_exp(1, S_FLUSHD, 1); push_exp(1, S_FLUSHE, 1);
      push_exp(3, S_RES, 2); push_exp(3, S_RD, 1); push_exp(3, S_RW, 1);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (pc_src_e === 2'b10) n_pass++;
      else $display("FAIL direct pc_src_e on jalr: got %0h", pc_src_e);
      tick(JAL0, 1'b0, 1'b0, 1'b0); push_exp(0, S_IMM, 3); push_exp(1, S_PCSRC, 1);
      tick(NOP, 1'b0, 1'b0, 1'b0);

      // Illegal encodings and U-type
      tick(ILL, 1'b0, 1'b0, 1'b0);
      push_exp(1, S_FLUSHE, 0); push_exp(2, S_MEMW, 0);
      push_exp(3, S_ILL, 1); push_exp(3, S_RW, 0); push_exp(4, S_ILL, 0);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      tick(MUL, 1'b0, 1'b0, 1'b0); push_exp(3, S_ILL, 1); push_exp(3, S_RW, 0);
      tick(NOP, 1'b0, 1'b0, 1'b0);
      tick(LUI9, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_IMM, 4); push_exp(3, S_RES, 3); push_exp(3, S_RD, 9); push_exp(3, S_D2ILL, 1);
      tick(AUIPC, 1'b0, 1'b0, 1'b0); push_exp(1, S_APC, 1); push_exp(1, S_ALUSRC, 1);
      tick(SRAI, 1'b0, 1'b0, 1'b0); push_exp(1, S_ALUC, 11);

      // Reset mid-stream with a load in E
      tick(LW5, 1'b0, 1'b0, 1'b0);
      tick(ADD6, 1'b0, 1'b0, 1'b0); rst = 1'b1; push_exp(0, S_ALL, 0);
      #1;
      n_checks++;
      if ({stall_f, stall_d, flush_d, flush_e, pc_src_e, imm_src_d} === 9'd0) n_pass++;
      else $display("FAIL direct outputs not cleared by async reset");
      n_checks++;
      if (reg_write_w === 1'b0) n_pass++;
      else $display("FAIL direct reg_write_w during reset: got %0b", reg_write_w);
      tick(NOP, 1'b0, 1'b0, 1'b0); push_exp(0, S_ALL, 0);
      tick(NOP, 1'b0, 1'b0, 1'b0); rst = 1'b0; push_exp(0, S_ALL, 0);
      tick(ADD6, 1'b0, 1'b0, 1'b0);
      push_exp(0, S_STALLF, 0); push_exp(1, S_RW, 0); push_exp(3, S_RD, 6); push_exp(3, S_RW, 1);

      repeat (6) tick(NOP, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      foreach (sb[i]) begin
         n_checks++;
         $display("FAIL %s cycle %0d: never compared expected %0h",
                  sel_name(sb[i].sel), sb[i].cyc, sb[i].val);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
